// File: rtl/logic_flag_unit.sv
// Registered logic/increment unit with valid/ready handshakes, per-result flags,
// sticky flag accumulation and a saturating count of zero results.
module logic_flag_unit #(
   parameter int WIDTH     = 4,
   parameter int CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [2:0]           op,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out,
   output logic                 z,
   output logic                 n,
   output logic                 cf,
   output logic                 v,
   input  logic                 clr_sticky,
   output logic                 sz,
   output logic                 sn,
   output logic                 scf,
   output logic                 sv,
   output logic [CNT_WIDTH-1:0] zcnt
);

   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH:0]   ONE_X   = {{WIDTH{1'b0}}, 1'b1};

   logic [WIDTH:0]   ext_p0;
   logic [WIDTH-1:0] res_p0;
   logic             cf_p0;
   logic             v_p0;

   logic             vld_p1;
   logic [WIDTH-1:0] out_p1;
   logic             z_p1;
   logic             n_p1;
   logic             cf_p1;
   logic             v_p1;

   logic             accept;
   logic             xfer;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt,
                                                    input logic inc);
      if (inc && (cnt != {CNT_WIDTH{1'b1}}))
         return cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      return cnt;
   endfunction

   // Stage p0: combinational operation; arithmetic carried one bit wider for CF
   always_comb begin
      ext_p0 = '0;
      res_p0 = '0;
      cf_p0  = 1'b0;
      v_p0   = 1'b0;
      case (op)
         3'b000: res_p0 = ~a;
         3'b001: res_p0 = a & b;
         3'b010: res_p0 = a | b;
         3'b011: res_p0 = a ^ b;
         3'b100: begin
            ext_p0 = {1'b0, ~a} + ONE_X;
            res_p0 = ext_p0[WIDTH-1:0];
            cf_p0  = ext_p0[WIDTH];
            v_p0   = (a == MIN_NEG);
         end
         3'b101: begin
            ext_p0 = {1'b0, a} + ONE_X;
            res_p0 = ext_p0[WIDTH-1:0];
            cf_p0  = ext_p0[WIDTH];
            v_p0   = (a == MAX_POS);
         end
         3'b110: begin
            ext_p0 = {1'b0, a} - ONE_X;
            res_p0 = ext_p0[WIDTH-1:0];
            cf_p0  = ext_p0[WIDTH];
            v_p0   = (a == MIN_NEG);
         end
         default: res_p0 = a;
      endcase
   end

   assign in_ready = !vld_p1 || out_ready;
   assign accept   = in_valid && in_ready;
   assign xfer     = vld_p1 && out_ready;

   // Stage p1: result register, held while downstream stalls
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1 <= 1'b0;
         out_p1 <= '0;
         z_p1   <= 1'b0;
         n_p1   <= 1'b0;
         cf_p1  <= 1'b0;
         v_p1   <= 1'b0;
      end else if (accept) begin
         vld_p1 <= 1'b1;
         out_p1 <= res_p0;
         z_p1   <= (res_p0 == '0);
         n_p1   <= res_p0[WIDTH-1];
         cf_p1  <= cf_p0;
         v_p1   <= v_p0;
      end else if (xfer) begin
         vld_p1 <= 1'b0;
      end
   end

   // Sticky flags and zero counter; a clear coinciding with a transfer keeps that result
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sz   <= 1'b0;
         sn   <= 1'b0;
         scf  <= 1'b0;
         sv   <= 1'b0;
         zcnt <= '0;
      end else if (clr_sticky) begin
         sz   <= xfer & z_p1;
         sn   <= xfer & n_p1;
         scf  <= xfer & cf_p1;
         sv   <= xfer & v_p1;
         zcnt <= {{(CNT_WIDTH-1){1'b0}}, xfer & z_p1};
      end else if (xfer) begin
         sz   <= sz  | z_p1;
         sn   <= sn  | n_p1;
         scf  <= scf | cf_p1;
         sv   <= sv  | v_p1;
         zcnt <= sat_inc(zcnt, z_p1);
      end
   end

   assign out_valid = vld_p1;
   assign out       = out_p1;
   assign z         = z_p1;
   assign n         = n_p1;
   assign cf        = cf_p1;
   assign v         = v_p1;

endmodule

// File: tb/tb_logic_flag_unit.sv
// Directed bench for logic_flag_unit (WIDTH=4, CNT_WIDTH=2) with an integer
// reference model compared every cycle plus literal expectations.
module tb_logic_flag_unit;

   localparam int W    = 4;
   localparam int CW   = 2;
   localparam int ZMAX = 3;

   localparam logic [2:0] OP_NOT = 3'b000, OP_AND = 3'b001, OP_OR  = 3'b010, OP_XOR = 3'b011;
   localparam logic [2:0] OP_NEG = 3'b100, OP_INC = 3'b101, OP_DEC = 3'b110, OP_PASS = 3'b111;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [2:0]    op = 3'b000;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  out;
   logic          z, n, cf, v;
   logic          clr_sticky = 1'b0;
   logic          sz, sn, scf, sv;
   logic [CW-1:0] zcnt;

   int n_checks = 0;
   int n_fail   = 0;

   logic_flag_unit #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .out(out),
      .z(z), .n(n), .cf(cf), .v(v), .clr_sticky(clr_sticky),
      .sz(sz), .sn(sn), .scf(scf), .sv(sv), .zcnt(zcnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: integer arithmetic on the operation definitions
   int m_valid = 0, m_out = 0, m_z = 0, m_n = 0, m_cf = 0, m_v = 0;
   int m_sz = 0, m_sn = 0, m_scf = 0, m_sv = 0, m_zcnt = 0;

   task automatic model_op(input int o, input int aa, input int bb,
                           output int r, output int c, output int ov);
      int sa;
      sa = (aa >= 8) ? aa - 16 : aa;
      c  = 0;
      ov = 0;
      case (o)
         0: r = 15 - aa;
         1: r = aa & bb;
         2: r = aa | bb;
         3: r = aa ^ bb;
         4: begin r = (16 - aa) % 16; c = (aa == 0); ov = (-sa > 7); end
         5: begin r = (aa + 1) % 16;  c = (aa + 1 > 15); ov = (sa + 1 > 7); end
         6: begin r = (aa + 15) % 16; c = (aa < 1); ov = (sa - 1 < -8); end
         default: r = aa;
      endcase
   endtask

   always @(posedge clk or posedge rst) begin
      int r, c, ov, acc, xf;
      if (rst) begin
         m_valid = 0; m_out = 0; m_z = 0; m_n = 0; m_cf = 0; m_v = 0;
         m_sz = 0; m_sn = 0; m_scf = 0; m_sv = 0; m_zcnt = 0;
      end else begin
         xf  = m_valid && out_ready;
         acc = in_valid && (!m_valid || out_ready);
         if (clr_sticky) begin
            m_sz = 0; m_sn = 0; m_scf = 0; m_sv = 0; m_zcnt = 0;
         end
         if (xf) begin
            m_sz  = m_sz | m_z;
            m_sn  = m_sn | m_n;
            m_scf = m_scf | m_cf;
            m_sv  = m_sv | m_v;
            if (m_z && m_zcnt < ZMAX) m_zcnt = m_zcnt + 1;
         end
         if (acc) begin
            model_op(int'(op), int'(a), int'(b), r, c, ov);
            m_valid = 1; m_out = r; m_z = (r == 0); m_n = (r >= 8); m_cf = c; m_v = ov;
         end else if (xf) begin
            m_valid = 0;
         end
      end
   end

   always @(negedge clk) begin
      check("m_in_ready", in_ready, (!m_valid || out_ready));
      check("m_out_valid", out_valid, m_valid);
      if (m_valid) begin
         check("m_out", out, m_out);
         check("m_flags", {z, n, cf, v}, {m_z[0], m_n[0], m_cf[0], m_v[0]});
      end
      check("m_sticky", {sz, sn, scf, sv}, {m_sz[0], m_sn[0], m_scf[0], m_sv[0]});
      check("m_zcnt", zcnt, m_zcnt);
   end

   task automatic drive(input logic iv, input logic [2:0] o, input logic [W-1:0] aa,
                        input logic [W-1:0] bb, input logic ordy, input logic clr);
      in_valid = iv; op = o; a = aa; b = bb; out_ready = ordy; clr_sticky = clr;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      drive(0, OP_NOT, 0, 0, 1, 0);
      repeat (2) tick();
      check("rst_out_valid", out_valid, 0);
      check("rst_out", out, 0);
      check("rst_flags", {z, n, cf, v, sz, sn, scf, sv}, 0);
      check("rst_zcnt", zcnt, 0);
      rst = 1'b0;
      tick();

      // back-to-back NOT
      drive(1, OP_NOT, 4'b0000, 0, 1, 0);
      check("not_in_ready0", in_ready, 1);
      tick();
      check("not0_out", out, 4'b1111);
      check("not0_flags", {z, n, cf}, 3'b010);
      drive(1, OP_NOT, 4'b1111, 0, 1, 0);
      check("not_in_ready1", in_ready, 1);
      tick();
      check("not1_out", out, 4'b0000);
      check("not1_z", z, 1);

      drive(1, OP_INC, 4'b1111, 0, 1, 0);
      tick();
      check("inc_wrap", {out, z, cf, v}, {4'b0000, 3'b110});
      drive(1, OP_INC, 4'b0111, 0, 1, 0);
      tick();
      check("inc_ovf", {out, n, v, cf}, {4'b1000, 3'b110});
      drive(1, OP_DEC, 4'b1000, 0, 1, 0);
      tick();
      check("dec_ovf", {out, v, cf}, {4'b0111, 2'b10});
      drive(1, OP_NEG, 4'b0000, 0, 1, 0);
      tick();
      check("neg_zero", {out, z, cf}, {4'b0000, 2'b11});
      drive(1, OP_XOR, 4'b1001, 4'b1001, 1, 0);
      tick();
      check("xor_zero", {out, z}, {4'b0000, 1'b1});
      drive(1, OP_AND, 4'b1010, 4'b0101, 1, 0);
      tick();
      check("and_zero", {out, z}, {4'b0000, 1'b1});
      drive(0, OP_AND, 0, 0, 1, 0);
      tick();
      check("drain_valid", out_valid, 0);
      check("zcnt_sat", zcnt, 3);
      check("sticky_all", {sz, sn, scf, sv}, 4'b1111);

      // clear coinciding with a zero-result transfer
      drive(1, OP_XOR, 4'b0110, 4'b0110, 1, 0);
      tick();
      drive(0, OP_XOR, 0, 0, 1, 1);
      tick();
      check("clr_zcnt", zcnt, 1);
      check("clr_sticky", {sz, sn, scf, sv}, 4'b1000);
      drive(1, OP_OR, 4'b0100, 4'b0001, 1, 0);
      tick();
      check("or_out", out, 4'b0101);

      // backpressure
      drive(1, OP_PASS, 4'b0101, 0, 1, 0);
      tick();
      drive(1, OP_PASS, 4'b1010, 0, 0, 0);
      check("bp_in_ready", in_ready, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("bp_hold", {out_valid, in_ready, out, z, n}, {2'b10, 4'b0101, 2'b00});
      end
      drive(1, OP_PASS, 4'b1010, 0, 1, 0);
      check("bp_release_ready", in_ready, 1);
      tick();
      check("bp_next", {out_valid, out, n}, {1'b1, 4'b1010, 1'b1});
      drive(0, OP_PASS, 0, 0, 1, 0);
      tick();
      check("bp_drain", out_valid, 0);

      // asynchronous reset while a stalled result is pending
      drive(1, OP_PASS, 4'b0011, 0, 1, 0);
      tick();
      drive(0, OP_PASS, 0, 0, 0, 0);
      tick();
      check("pre_rst", {out_valid, out}, {1'b1, 4'b0011});
      #2 rst = 1'b1;
      #1;
      check("arst_valid_out", {out_valid, out}, 0);
      check("arst_flags", {z, n, cf, v, sz, sn, scf, sv}, 0);
      check("arst_zcnt", zcnt, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      drive(1, OP_INC, 4'b0010, 0, 1, 0);
      tick();
      check("post_rst", {out_valid, out}, {1'b1, 4'b0011});
      drive(0, OP_PASS, 0, 0, 1, 0);
      repeat (2) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
